// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined N-bit adder/subtractor with valid/ready streaming
//
// Purpose:
//   Adds or subtracts two N-bit operands. The carry chain is cut into STAGES
//   registered segments of W = N/STAGES bits. Stage k adds bits [k*W +: W];
//   the not-yet-added operand slices travel with the carry. Status flags are
//   formed in the last stage and registered together with the result.
//   Subtract is computed as A + ~B + 1, so C_In only matters when adding.
//
// Configuration macro:
//   SATURATE_EN - when defined, an overflowing result is clamped to the limit
//                 of the selected mode; Overflow is still reported.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   In_Valid / In_Ready    operand handshake
//   A, B, C_In             operands and carry in
//   Add_Sub                1 = A+B+C_In, 0 = A-B
//   Signed                 1 = two's-complement, 0 = unsigned
//   Out_Valid / Out_Ready  result handshake
//   Out                    N-bit result
//   Carry_Out              raw MSB carry (subtract: 1 = no borrow)
//   Overflow               result not representable in the selected mode
//   Zero                   Out == 0
module pipelined_add_sub #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_In,
  input  logic         Add_Sub,
  input  logic         Signed,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic [N-1:0] Out,
  output logic         Carry_Out,
  output logic         Overflow,
  output logic         Zero
);

  localparam int W = N / STAGES;
  localparam int L = STAGES - 1;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  logic advance;
  assign advance  = !Out_Valid || Out_Ready;
  assign In_Ready = advance;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    // Operand slices still to be added: bits [N-1:k*W] of A and effective B.
    logic [N-k*W-1:0]   a_in;
    logic [N-k*W-1:0]   b_in;
    logic               c_in;
    logic               v_in;
    logic               sg_in;
    logic               add_in;
    logic [W:0]         seg;
    logic [(k+1)*W-1:0] s_next;

    assign seg = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};

    if (k == 0) begin : g_src
      assign a_in   = A;
      assign b_in   = Add_Sub ? B : ~B;
      assign c_in   = Add_Sub ? C_In : 1'b1;
      assign v_in   = In_Valid;
      assign sg_in  = Signed;
      assign add_in = Add_Sub;
      assign s_next = seg[W-1:0];
    end else begin : g_src
      assign a_in   = g_stage[k-1].g_reg.a_q;
      assign b_in   = g_stage[k-1].g_reg.b_q;
      assign c_in   = g_stage[k-1].g_reg.c_q;
      assign v_in   = g_stage[k-1].g_reg.v_q;
      assign sg_in  = g_stage[k-1].g_reg.sg_q;
      assign add_in = g_stage[k-1].g_reg.add_q;
      assign s_next = {seg[W-1:0], g_stage[k-1].g_reg.s_q};
    end

    // The last stage has no register of its own here; its result feeds the
    // output register below together with the flags.
    if (k < L) begin : g_reg
      logic [N-(k+1)*W-1:0] a_q;
      logic [N-(k+1)*W-1:0] b_q;
      logic [(k+1)*W-1:0]   s_q;
      logic                 c_q;
      logic                 v_q;
      logic                 sg_q;
      logic                 add_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          s_q   <= '0;
          c_q   <= 1'b0;
          v_q   <= 1'b0;
          sg_q  <= 1'b0;
          add_q <= 1'b0;
        end else if (advance) begin
          v_q <= v_in;
          if (v_in) begin
            a_q   <= a_in[N-k*W-1:W];
            b_q   <= b_in[N-k*W-1:W];
            s_q   <= s_next;
            c_q   <= seg[W];
            sg_q  <= sg_in;
            add_q <= add_in;
          end
        end
      end
    end
  end

  logic [N-1:0] fin_sum;
  logic         fin_c;
  logic         fin_v;
  logic         fin_sg;
  logic         fin_add;
  logic         a_msb;
  logic         b_msb;
  logic         ovf;
  logic [N-1:0] res;

  assign fin_sum = g_stage[L].s_next;
  assign fin_c   = g_stage[L].seg[W];
  assign fin_v   = g_stage[L].v_in;
  assign fin_sg  = g_stage[L].sg_in;
  assign fin_add = g_stage[L].add_in;
  assign a_msb   = g_stage[L].a_in[W-1];
  assign b_msb   = g_stage[L].b_in[W-1];

  // b_msb is the sign of the effective (already inverted for subtract) B.
  assign ovf = fin_sg ? ((a_msb == b_msb) && (fin_sum[N-1] != a_msb))
                      : (fin_add ? fin_c : !fin_c);

`ifdef SATURATE_EN
  // Signed overflow direction follows the common operand sign: a positive
  // operand pair can only overflow upwards.
  always_comb begin
    res = fin_sum;
    if (ovf) begin
      if (fin_sg)
        res = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      else
        res = fin_add ? {N{1'b1}} : {N{1'b0}};
    end
  end
`else
  assign res = fin_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out_Valid <= 1'b0;
      Out       <= '0;
      Carry_Out <= 1'b0;
      Overflow  <= 1'b0;
      Zero      <= 1'b0;
    end else if (advance) begin
      Out_Valid <= fin_v;
      if (fin_v) begin
        Out       <= res;
        Carry_Out <= fin_c;
        Overflow  <= ovf;
        Zero      <= (res == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - scoreboard bench for pipelined_add_sub (N=8, STAGES=2)
module tb_pipelined_add_sub;

  localparam int N   = 8;
  localparam int STG = 2;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [7:0] out;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         In_Valid = 1'b0;
  logic         In_Ready;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         C_In = 1'b0;
  logic         Add_Sub = 1'b1;
  logic         Signed = 1'b0;
  logic         Out_Valid;
  logic         Out_Ready = 1'b1;
  logic [N-1:0] Out;
  logic         Carry_Out;
  logic         Overflow;
  logic         Zero;

  int   n_cmp = 0;
  int   n_err = 0;
  int   stall_cnt = 0;
  int   res_idx = 0;
  exp_t q[$];

  pipelined_add_sub #(.N(N), .STAGES(STG)) dut (
    .clk(clk), .rst_n(rst_n),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .A(A), .B(B), .C_In(C_In), .Add_Sub(Add_Sub), .Signed(Signed),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out(Out),
    .Carry_Out(Carry_Out), .Overflow(Overflow), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] o_wrap, input logic [7:0] o_sat,
                              input logic c, input logic v);
    exp_t e;
    e.out = SAT ? o_sat : o_wrap;
    e.c   = c;
    e.v   = v;
    e.z   = (e.out == 8'h00);
    return e;
  endfunction

  // Drives one operand set and holds it until the DUT takes it; returns
  // just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic add, input logic sgn, input logic push, input exp_t e);
    logic acc;
    #1;
    A = a; B = b; C_In = cin; Add_Sub = add; Signed = sgn; In_Valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = In_Ready;
      @(posedge clk);
    end
    chk("accept", {31'd0, acc}, 32'd1);
    if (acc && push) q.push_back(e);
  endtask

  task automatic idle();
    #1 In_Valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor: compares whenever a result is presented; while stalled the
  // same expected entry is compared every cycle, so the output must hold.
  always @(negedge clk) begin
    if (rst_n && Out_Valid) begin
      if (q.size() == 0) begin
        chk("unexpected_result", {31'd0, Out_Valid}, 32'd0);
      end else begin
        chk($sformatf("out[%0d]", res_idx), Out, q[0].out);
        chk($sformatf("carry[%0d]", res_idx), Carry_Out, q[0].c);
        chk($sformatf("ovf[%0d]", res_idx), Overflow, q[0].v);
        chk($sformatf("zero[%0d]", res_idx), Zero, q[0].z);
        if (Out_Ready) begin
          void'(q.pop_front());
          res_idx++;
        end else begin
          stall_cnt++;
          chk("in_ready_stall", In_Ready, 0);
        end
      end
    end
  end

  initial begin
    exp_t nx;
    nx = mk(8'h00, 8'h00, 1'b0, 1'b0);

    // Reset state while clock runs.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_out", Out, 0);
    chk("rst_carry", Carry_Out, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_zero", Zero, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", In_Ready, 1);
    @(posedge clk);

    // Unsigned add with carry in, plus latency check.
    send(8'hF0, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, mk(8'h11, 8'hFF, 1'b1, 1'b1));
    idle();
    for (int i = 0; i < STG - 1; i++) begin
      @(negedge clk);
      chk("lat_not_yet", Out_Valid, 0);
    end
    @(negedge clk);
    chk("lat_valid", Out_Valid, 1);
    drain();

    // Signed subtract: C_In must be ignored.
    send(8'h05, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, mk(8'hFE, 8'hFE, 1'b0, 1'b0));
    // Signed overflow both directions.
    send(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, mk(8'h80, 8'h7F, 1'b0, 1'b1));
    send(8'h80, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, mk(8'h7F, 8'h80, 1'b1, 1'b1));
    idle();
    drain();

    // Six back-to-back ops with a 3-cycle output stall mid-stream.
    fork
      begin
        send(8'h0F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, mk(8'h10, 8'h10, 1'b0, 1'b0));
        send(8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, mk(8'h00, 8'h00, 1'b1, 1'b0));
        send(8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, mk(8'hFE, 8'h00, 1'b0, 1'b1));
        send(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, mk(8'h00, 8'hFF, 1'b1, 1'b1));
        send(8'h80, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, mk(8'h7F, 8'h80, 1'b1, 1'b1));
        send(8'h40, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b1, mk(8'h80, 8'h7F, 1'b0, 1'b1));
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 Out_Ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 Out_Ready = 1'b1;
      end
    join
    drain();
    chk("stall_cycles", stall_cnt, 3);
    chk("results_seen", res_idx, 10);

    // Reset with two ops in flight; neither may emerge afterwards.
    send(8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, nx);
    send(8'h33, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0, nx);
    #1 rst_n = 1'b0;
    In_Valid = 1'b0;
    #1;
    chk("midrst_out_valid", Out_Valid, 0);
    chk("midrst_out", Out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", Out_Valid, 0);
    end
    chk("post_rst_in_ready", In_Ready, 1);
    @(posedge clk);

    // Pipeline is usable again after reset.
    send(8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, mk(8'h02, 8'h02, 1'b0, 1'b0));
    idle();
    drain();
    chk("results_total", res_idx, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
